// File: rtl/crc5_pkg.sv
// crc5_pkg: frame states, CRC-5 constants and mode encodings shared by the controller
package crc5_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, APPEND} state_t;
  localparam logic [4:0] CRC5_INIT = 5'h1F;
  localparam logic [4:0] CRC5_XOROUT = 5'h1F;
  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHECK = 1'b1;
endpackage

// File: rtl/crc5_frame_ctrl_if.sv
// crc5_frame_ctrl_if: byte stream in/out handshakes plus frame status
interface crc5_frame_ctrl_if;
  logic mode;
  logic [7:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [7:0] out_data;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic busy;
  logic done;
  logic [4:0] crc_value;
  logic crc_err;
  modport master(
    output mode, in_data, in_valid, in_last, out_ready,
    input in_ready, out_data, out_valid, out_last, busy, done, crc_value, crc_err
  );
  modport slave(
    input mode, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, done, crc_value, crc_err
  );
endinterface

// File: rtl/crc5_byte_step.sv
// crc5_byte_step: advances the CRC-5 LFSR by one data byte
module crc5_byte_step (
  input  logic [4:0] q,
  input  logic [7:0] d,
  output logic [4:0] c
);
  assign c[0] = q[0] ^ q[2] ^ q[3] ^ d[0] ^ d[3] ^ d[5] ^ d[6];
  assign c[1] = q[1] ^ q[3] ^ q[4] ^ d[1] ^ d[4] ^ d[6] ^ d[7];
  assign c[2] = q[0] ^ q[3] ^ q[4] ^ d[0] ^ d[2] ^ d[3] ^ d[6] ^ d[7];
  assign c[3] = q[0] ^ q[1] ^ q[4] ^ d[1] ^ d[3] ^ d[4] ^ d[7];
  assign c[4] = q[1] ^ q[2] ^ d[2] ^ d[4] ^ d[5];
endmodule

// File: rtl/crc5_frame_ctrl.sv
// crc5_frame_ctrl: forwards a byte stream, appending or checking a trailing CRC-5 byte per frame
module crc5_frame_ctrl
  import crc5_pkg::*;
#(
  parameter logic [4:0] INIT = CRC5_INIT,
  parameter logic [4:0] XOROUT = CRC5_XOROUT
) (
  input logic ck,
  input logic rst,
  crc5_frame_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [4:0] lfsr, crc_fin, q, c;
  logic mode_r, m, acc, free, fin, chk_last;
  assign free = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = (state != APPEND) & free;
  assign bus.busy = state != IDLE;
  assign acc = bus.in_valid & bus.in_ready;
  assign q = state == IDLE ? INIT : lfsr;
  assign m = state == IDLE ? bus.mode : mode_r;
  assign chk_last = acc & bus.in_last & (m == MODE_CHECK);
  assign fin = (state == APPEND) & free;
  crc5_byte_step u_step (.q(q), .d(bus.in_data), .c(c));
  // frame state register
  always_ff @(posedge ck or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state: APPEND waits for a free output slot, otherwise follow accepted bytes
  always_comb begin
    state_nx = state;
    if (state == APPEND) state_nx = free ? IDLE : APPEND;
    else if (acc) state_nx = !bus.in_last ? ACCUM : (m == MODE_GEN ? APPEND : IDLE);
  end
  // LFSR, output register and frame result
  always_ff @(posedge ck or negedge rst)
    if (!rst) begin
      lfsr <= INIT;
      crc_fin <= '0;
      mode_r <= MODE_GEN;
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.done <= 1'b0;
      bus.crc_value <= '0;
      bus.crc_err <= 1'b0;
    end else begin
      bus.done <= fin | chk_last;
      if (acc && state == IDLE) mode_r <= bus.mode;
      if (acc && !chk_last) lfsr <= c;
      if (acc && bus.in_last && m == MODE_GEN) crc_fin <= c ^ XOROUT;
      if (acc) begin
        bus.out_data <= bus.in_data;
        bus.out_valid <= 1'b1;
        bus.out_last <= chk_last;
      end else if (fin) begin
        bus.out_data <= {3'b000, crc_fin};
        bus.out_valid <= 1'b1;
        bus.out_last <= 1'b1;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
      if (fin) begin
        bus.crc_value <= crc_fin;
        bus.crc_err <= 1'b0;
      end else if (chk_last) begin
        bus.crc_value <= q ^ XOROUT;
        bus.crc_err <= (bus.in_data[7:5] != 3'b000) | (bus.in_data[4:0] != (q ^ XOROUT));
      end
    end
endmodule

// File: tb/tb_crc5_frame_ctrl.sv
// tb_crc5_frame_ctrl: scoreboard bench with a mask-parity CRC-5 reference model
module tb_crc5_frame_ctrl;
  import crc5_pkg::*;
  typedef struct {logic [7:0] d; logic l;} ob_t;
  typedef struct {logic [4:0] v; logic e;} od_t;
  localparam logic [4:0] QM [5] = '{5'b01101, 5'b11010, 5'b11001, 5'b10011, 5'b00110};
  localparam logic [7:0] DM [5] = '{8'b01101001, 8'b11010010, 8'b11001101, 8'b10011010, 8'b00110100};
  logic ck = 1'b0;
  logic rst = 1'b0;
  int checks = 0, fails = 0, done_cnt = 0, hold = 2;
  ob_t exp_o[$];
  od_t exp_d[$];
  logic [7:0] frm[$];
  always #5 ck = ~ck;
  crc5_frame_ctrl_if bus();
  crc5_frame_ctrl dut (.ck(ck), .rst(rst), .bus(bus));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // CRC over the first cnt bytes of frm: each output bit is the parity of masked state and data
  function automatic logic [4:0] model_crc(input int cnt);
    logic [4:0] r = CRC5_INIT;
    logic [4:0] n;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 5; k++) n[k] = (^(r & QM[k])) ^ (^(frm[i] & DM[k]));
      r = n;
    end
    return r ^ CRC5_XOROUT;
  endfunction

  // downstream ready: random, forced low, or forced high
  always @(posedge ck) begin
    #1;
    bus.out_ready = hold == 1 ? 1'b0 : hold == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // monitor: pop and compare on each output transfer and each done pulse
  always @(negedge ck) if (rst) begin
    ob_t eo;
    od_t ed;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_o.size() == 0) begin
        checks++; fails++;
        $display("FAIL out_extra: got %0h expected no byte", bus.out_data);
      end else begin
        eo = exp_o.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(eo.d));
        chk("out_last", 32'(bus.out_last), 32'(eo.l));
      end
    end
    if (bus.done) begin
      done_cnt++;
      if (exp_d.size() == 0) begin
        checks++; fails++;
        $display("FAIL done_extra: got done expected none");
      end else begin
        ed = exp_d.pop_front();
        chk("crc_value", 32'(bus.crc_value), 32'(ed.v));
        chk("crc_err", 32'(bus.crc_err), 32'(ed.e));
      end
    end
  end

  task automatic send_frame(input logic m);
    int n = frm.size();
    int t;
    logic [4:0] cv = model_crc(m == MODE_GEN ? n : n - 1);
    for (int i = 0; i < n; i++) exp_o.push_back('{d: frm[i], l: (m == MODE_CHECK) && (i == n - 1)});
    if (m == MODE_GEN) begin
      exp_o.push_back('{d: {3'b000, cv}, l: 1'b1});
      exp_d.push_back('{v: cv, e: 1'b0});
    end else exp_d.push_back('{v: cv, e: frm[n-1] != {3'b000, cv}});
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = frm[i];
      bus.in_last = i == n - 1;
      bus.mode = i == 0 ? m : ~m;
      t = 0;
      while (1) begin
        @(negedge ck);
        if (bus.in_ready || ++t >= 200) break;
      end
      if (t >= 200) begin
        checks++; fails++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
      end
      @(posedge ck); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_o.size() != 0 || exp_d.size() != 0 || bus.busy || bus.out_valid) && t < 500) begin
      @(posedge ck); #1;
      t++;
    end
    if (t >= 500) begin
      checks++; fails++;
      $display("FAIL idle_timeout: got %0d pending expected 0", exp_o.size() + exp_d.size());
    end
  endtask

  initial begin
    int d0, n;
    logic m;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.mode = MODE_GEN;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_crc_value", 32'(bus.crc_value), 0);
    chk("rst_crc_err", 32'(bus.crc_err), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    rst = 1'b1;
    @(posedge ck); #1;
    frm = '{8'h00}; send_frame(MODE_GEN); wait_idle();
    chk("gen00_crc", 32'(bus.crc_value), 32'h10);
    frm = '{8'hFF}; send_frame(MODE_GEN); wait_idle();
    chk("genFF_crc", 32'(bus.crc_value), 32'h04);
    frm = '{8'h00, 8'h10}; send_frame(MODE_CHECK); wait_idle();
    chk("chk_ok_err", 32'(bus.crc_err), 0);
    frm = '{8'h00, 8'h11}; send_frame(MODE_CHECK); wait_idle();
    chk("chk_bad_err", 32'(bus.crc_err), 1);
    frm = '{8'h00, 8'h30}; send_frame(MODE_CHECK); wait_idle();
    chk("chk_upper_err", 32'(bus.crc_err), 1);
    hold = 1;
    repeat (2) begin @(posedge ck); #1; end
    d0 = done_cnt;
    frm = '{8'h00}; send_frame(MODE_GEN);
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 32'h00);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_done", 32'(bus.done), 0);
    end
    @(posedge ck); #1;
    chk("bp_no_done", 32'(done_cnt - d0), 0);
    hold = 2;
    wait_idle();
    chk("bp_crc", 32'(bus.crc_value), 32'h10);
    d0 = done_cnt;
    frm = '{8'h00}; send_frame(MODE_GEN);
    frm = '{8'h00, 8'h10}; send_frame(MODE_CHECK);
    wait_idle();
    chk("b2b_dones", 32'(done_cnt - d0), 2);
    chk("b2b_err", 32'(bus.crc_err), 0);
    hold = 0;
    repeat (40) begin
      n = $urandom_range(1, 6);
      m = 1'($urandom_range(0, 1));
      frm.delete();
      for (int i = 0; i < n - 1; i++) frm.push_back(8'($urandom));
      if (m == MODE_CHECK && $urandom_range(0, 1) == 1) frm.push_back({3'b000, model_crc(n - 1)});
      else frm.push_back(8'($urandom));
      send_frame(m);
      repeat ($urandom_range(0, 2)) begin @(posedge ck); #1; end
    end
    wait_idle();
    hold = 2;
    @(posedge ck); #1;
    d0 = done_cnt;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    bus.in_last = 1'b0;
    bus.mode = MODE_GEN;
    @(negedge ck);
    chk("mid_accept_ready", 32'(bus.in_ready), 1);
    @(posedge ck); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_out_data", 32'(bus.out_data), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_done", 32'(bus.done), 0);
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b1;
    @(posedge ck); #1;
    chk("mid_no_done", 32'(done_cnt - d0), 0);
    frm = '{8'hFF}; send_frame(MODE_GEN); wait_idle();
    chk("post_rst_crc", 32'(bus.crc_value), 32'h04);
    chk("leftover", 32'(exp_o.size() + exp_d.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/crc5_frame_ctrl.md
Name: crc5_frame_ctrl

Overview:
Frame-level controller for the team's byte-wide CRC-5 engine. It accepts a byte stream over a valid/ready handshake and forwards every byte downstream. In generate mode it appends one CRC byte to the frame; in check mode it validates the trailing CRC byte. It owns the LFSR state register, which it initialises, steps and finalises per frame, and the combinational step function is a sub-module. It sits between the packet source and the link serializer.

Parameters:
INIT, 5'h1F, LFSR value loaded at the first byte of each frame
XOROUT, 5'h1F, value XORed onto the LFSR to form the final CRC

Ports:
ck  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mode  in  1  0 = generate, 1 = check; sampled only when the first byte of a frame is accepted
in_data  in  8  input byte
in_valid  in  1  input byte valid
in_last  in  1  marks last input byte of frame
in_ready  out  1  controller can accept the byte
out_data  out  8  output byte
out_valid  out  1  output byte valid
out_last  out  1  marks last output byte of frame
out_ready  in  1  downstream accepts the byte
busy  out  1  a frame is in progress (state != IDLE)
done  out  1  one-cycle pulse at frame completion
crc_value  out  5  final CRC of the last frame, held until the next done
crc_err  out  1  check-mode result, valid at done and held until the next done; always 0 after a generate frame

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; lfsr=INIT; out_valid, out_last, done, crc_err and busy = 0; out_data=0; crc_value=0.
- Step function, where q is the LFSR and d is the data byte:
  c0=q0^q2^q3^d0^d3^d5^d6
  c1=q1^q3^q4^d1^d4^d6^d7
  c2=q0^q3^q4^d0^d2^d3^d6^d7
  c3=q0^q1^q4^d1^d3^d4^d7
  c4=q1^q2^d2^d4^d5
- Handshakes:
  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
  - There is a single output register: in_ready = (state != APPEND) & (!out_valid | out_ready).
  - in_ready does not depend on in_valid.
  - Output holds stable while out_valid & !out_ready.
- States: IDLE, ACCUM, APPEND.
  - IDLE: an accept latches mode. The step uses INIT as q, regardless of the lfsr register. Go to ACCUM, or apply the last-byte rule if in_last=1.
  - ACCUM: each accept steps lfsr with in_data.
  - Every accepted byte is loaded into the output register with a latency of 1 cycle.
- Last byte, generate mode:
  - Step as normal and forward it with out_last=0.
  - Store the final CRC, step_result^XOROUT, then go to APPEND.
- APPEND:
  - When the output register is free (!out_valid | out_ready), load {3'b000, final CRC} with out_last=1.
  - Same cycle: pulse done, set crc_value, clear crc_err, go to IDLE.
  - Earliest case: the CRC byte follows the last data byte on the next cycle.
- Last byte, check mode:
  - The byte is NOT stepped into the LFSR. It is forwarded with out_last=1.
  - crc_err = (in_data[7:5] != 0) | (in_data[4:0] != lfsr^XOROUT).
  - done pulses and crc_value is set on the cycle after the accept, and state returns to IDLE.
  - A single-byte check frame compares against INIT^XOROUT.
- Back-to-back frames: a new first byte is accepted on the cycle after return to IDLE. There is no idle gap beyond that.
- Reset mid-frame: the frame is discarded, with no done pulse and outputs cleared.
- mode changes mid-frame are ignored.

Decomposition:
- Shared package crc5_pkg holds:
  - the state enum (IDLE/ACCUM/APPEND),
  - the constants CRC5_INIT=5'h1F and CRC5_XOROUT=5'h1F,
  - the MODE_GEN/MODE_CHECK encodings.
- One combinational sub-module crc5_byte_step: inputs q[4:0] and d[7:0], output c[4:0], implementing the equations above. It is instantiated once.

Test Plan:
- Generate, 1-byte frame 0x00 (in_last=1), out_ready=1 -> out 0x00 (last=0) then 0x10 (last=1); done with crc_value=5'h10, crc_err=0.
- Generate, 1-byte frame 0xFF -> out 0xFF then 0x04 (last=1); crc_value=5'h04.
- Check frame {0x00,0x10} -> done, crc_err=0. Check frame {0x00,0x11} -> crc_err=1. Check frame {0x00,0x30} -> crc_err=1 (upper bits nonzero).
- Backpressure: generate frame {0x00}, out_ready held 0 for 5 cycles -> out_data stable at 0x00, in_ready=0, no done. After release, 0x10 follows and done fires.
- Back-to-back: generate {0x00} immediately followed by check {0x00,0x10} (mode toggled only at second first byte) -> two done pulses; second crc_err=0, with no bytes dropped or duplicated.
- Reset mid-frame: assert rst after 1 byte of a multi-byte frame -> outputs reset immediately. A following generate frame {0xFF} yields CRC byte 0x04, proving the LFSR was reinitialised.
